// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch control. Holds the architectural PC, keeps at most one
//   request outstanding to instruction memory (valid/ready), hands each fetched
//   word to decode (valid/ready), applies taken-branch redirects from execute
//   and squashes the response of a request made obsolete by a redirect.
//
// Ports
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   fetch_en                      gate for issuing new memory requests
//   branch, alu_zero              redirect = branch & alu_zero
//   branch_pc, branch_offset      redirect target = branch_pc + offset (word aligned)
//   imem_req_valid/addr/ready     request channel to instruction memory
//   imem_resp_valid/data          response channel (one per accepted request)
//   if_valid/if_pc/if_instr       instruction to decode, held until if_ready
//   if_ready                      decode accepts instruction
//   pc                            current fetch PC
//   misalign_err                  one-cycle pulse after a redirect to an unaligned target
//   fetch_count                   instructions accepted by decode (wraps)
module fetch_sequencer #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  branch,
  input  logic                  alu_zero,
  input  logic [PC_WIDTH-1:0]   branch_pc,
  input  logic signed [63:0]    branch_offset,
  output logic                  imem_req_valid,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [31:0]           imem_resp_data,
  output logic                  if_valid,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [31:0]           if_instr,
  input  logic                  if_ready,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  misalign_err,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc_q, pc_nxt;
  logic                   squash_q, squash_nxt;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_nxt;
  logic [31:0]            if_instr_q, if_instr_nxt;
  logic [CNT_WIDTH-1:0]   count_q, count_nxt;
  logic                   misalign_q, misalign_nxt;

  logic                   redirect;
  logic                   req_fire;
  logic [PC_WIDTH-1:0]    raw_target;
  logic [PC_WIDTH-1:0]    target;

  // Only the low PC_WIDTH bits of the offset take part in the modular add.
  wire unused_offset_bits = ^branch_offset[63:PC_WIDTH];

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

  assign redirect   = branch & alu_zero;
  assign raw_target = branch_pc + branch_offset[PC_WIDTH-1:0];
  assign target     = word_align(raw_target);

  assign imem_req_valid = (state == S_REQ) & fetch_en;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign if_valid     = (state == S_OUT);
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign pc           = pc_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      squash_q   <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      squash_q   <= squash_nxt;
      if_pc_q    <= if_pc_nxt;
      if_instr_q <= if_instr_nxt;
      count_q    <= count_nxt;
      misalign_q <= misalign_nxt;
    end
  end

  // Redirect is evaluated first in every state so it wins over handshakes.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    squash_nxt   = squash_q;
    if_pc_nxt    = if_pc_q;
    if_instr_nxt = if_instr_q;
    count_nxt    = count_q;
    misalign_nxt = redirect & (raw_target[1:0] != 2'b00);

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redirect) pc_nxt = target;
      end

      S_REQ: begin
        if (redirect) pc_nxt = target;
        if (req_fire) begin
          state_nxt = S_WAIT;
          // The request just accepted was for the old PC; its response is stale.
          if (redirect) squash_nxt = 1'b1;
        end
      end

      S_WAIT: begin
        if (redirect) pc_nxt = target;
        if (imem_resp_valid) begin
          if (squash_q || redirect) begin
            squash_nxt = 1'b0;
            state_nxt  = S_REQ;
          end else begin
            if_instr_nxt = imem_resp_data;
            if_pc_nxt    = pc_q;
            state_nxt    = S_OUT;
          end
        end else if (redirect) begin
          squash_nxt = 1'b1;
        end
      end

      S_OUT: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = S_REQ;
        end else if (if_ready) begin
          pc_nxt    = pc_q + PC_WIDTH'(4);
          count_nxt = count_q + CNT_WIDTH'(1);
          state_nxt = S_REQ;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               fetch_en;
  logic               branch;
  logic               alu_zero;
  logic [31:0]        branch_pc;
  logic signed [63:0] branch_offset;
  logic               imem_req_valid;
  logic [31:0]        imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [31:0]        imem_resp_data;
  logic               if_valid;
  logic [31:0]        if_pc;
  logic [31:0]        if_instr;
  logic               if_ready;
  logic [31:0]        pc;
  logic               misalign_err;
  logic [31:0]        fetch_count;

  int checks = 0;
  int errors = 0;

  // Memory response latency in cycles after the accepting edge.
  int          resp_delay = 1;
  int          mem_cnt;
  logic        mem_pend;
  logic [31:0] mem_addr;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .branch          (branch),
    .alu_zero        (alu_zero),
    .branch_pc       (branch_pc),
    .branch_offset   (branch_offset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready),
    .pc              (pc),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A is A + 0x1000_0000.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
      mem_pend        <= 1'b0;
      mem_cnt         <= 0;
      mem_addr        <= '0;
    end else begin
      imem_resp_valid <= 1'b0;
      if (mem_pend) begin
        if (mem_cnt == 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_addr + 32'h1000_0000;
          mem_pend        <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (imem_req_valid && imem_req_ready) begin
        if (resp_delay <= 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= imem_req_addr + 32'h1000_0000;
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= resp_delay - 1;
          mem_addr <= imem_req_addr;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redirect(input logic [31:0] bpc, input logic signed [63:0] off);
    branch        = 1'b1;
    alu_zero      = 1'b1;
    branch_pc     = bpc;
    branch_offset = off;
  endtask

  task automatic clear_redirect();
    branch   = 1'b0;
    alu_zero = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b0; clear_redirect(); branch_pc = '0; branch_offset = '0;
    imem_req_ready = 1'b0; if_ready = 1'b0;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
    @(posedge clk); #1;
    rst = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
    step();  // IDLE -> REQ
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      step();  // accept
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stream_wait_req[%0d] got %b want 0", i, imem_req_valid); end
      step();  // response latched
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4*i)) begin errors++; $display("FAIL stream_out[%0d] got v=%b pc=%h want v=1 pc=%h", i, if_valid, if_pc, 32'(4*i)); end
      checks++; if (if_instr !== 32'h1000_0000 + 32'(4*i)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, if_instr, 32'h1000_0000 + 32'(4*i)); end
      step();  // handoff
      checks++; if (fetch_count !== 32'(i+1)) begin errors++; $display("FAIL stream_count[%0d] got %0d want %0d", i, fetch_count, i+1); end
      checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*(i+1))) begin errors++; $display("FAIL stream_next[%0d] got v=%b rv=%b a=%h want v=0 rv=1 a=%h", i, if_valid, imem_req_valid, imem_req_addr, 32'(4*(i+1))); end
    end
  endtask

  task automatic test_backpressure();
    if_ready = 1'b0;
    step();  // accept addr 0xC
    step();  // OUT
    for (int k = 0; k < 6; k++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'h1000_000C) begin errors++; $display("FAIL hold[%0d] got v=%b pc=%h ins=%h want v=1 pc=c ins=1000000c", k, if_valid, if_pc, if_instr); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_noreq[%0d] got %b want 0", k, imem_req_valid); end
      if (k < 5) step();
    end
    if_ready = 1'b1;
    step();
    checks++; if (fetch_count !== 32'd4 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL hold_release got cnt=%0d a=%h want cnt=4 a=10", fetch_count, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    resp_delay = 2;
    step();  // accept 0x10, response arrives two edges later
    set_redirect(32'h10, 64'sh20);
    step();  // redirect in WAIT with no response yet -> squash
    clear_redirect();
    checks++; if (pc !== 32'h30 || if_valid !== 1'b0) begin errors++; $display("FAIL rw_pc got pc=%h v=%b want pc=30 v=0", pc, if_valid); end
    step();  // stale response dropped
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_stale got v=%b want 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h30) begin errors++; $display("FAIL rw_next_req got v=%b a=%h want v=1 a=30", imem_req_valid, imem_req_addr); end
    resp_delay = 1;
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h30 || if_instr !== 32'h1000_0030) begin errors++; $display("FAIL rw_out got v=%b pc=%h ins=%h want v=1 pc=30 ins=10000030", if_valid, if_pc, if_instr); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL rw_count got %0d want 4", fetch_count); end
    step();  // handoff
    checks++; if (fetch_count !== 32'd5 || pc !== 32'h34) begin errors++; $display("FAIL rw_handoff got cnt=%0d pc=%h want cnt=5 pc=34", fetch_count, pc); end
  endtask

  task automatic test_redirect_out();
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h34) begin errors++; $display("FAIL ro_out got v=%b pc=%h want v=1 pc=34", if_valid, if_pc); end
    set_redirect(32'h100, 64'sh40);
    if_ready = 1'b1;
    step();
    clear_redirect();
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL ro_count got %0d want 5", fetch_count); end
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h140) begin errors++; $display("FAIL ro_next got v=%b rv=%b a=%h want v=0 rv=1 a=140", if_valid, imem_req_valid, imem_req_addr); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL ro_misalign got %b want 0", misalign_err); end
  endtask

  task automatic test_misalign();
    fetch_en = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL ma_gate got %b want 0", imem_req_valid); end
    set_redirect(32'h200, 64'sh22);
    step();
    clear_redirect();
    checks++; if (misalign_err !== 1'b1 || pc !== 32'h220) begin errors++; $display("FAIL ma_pulse got err=%b pc=%h want err=1 pc=220", misalign_err, pc); end
    step();
    checks++; if (misalign_err !== 1'b0 || pc !== 32'h220 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL ma_after got err=%b pc=%h rv=%b want err=0 pc=220 rv=0", misalign_err, pc, imem_req_valid); end
    set_redirect(32'hFFFF_FFFC, 64'sh4);
    step();
    clear_redirect();
    checks++; if (pc !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL ma_wrap got pc=%h err=%b want pc=0 err=0", pc, misalign_err); end
    set_redirect(32'h100, -64'sd16);
    step();
    clear_redirect();
    checks++; if (pc !== 32'hF0) begin errors++; $display("FAIL ma_negoff got pc=%h want f0", pc); end
    fetch_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    step();  // accept 0xF0 -> WAIT
    checks++; if (imem_req_valid !== 1'b0 || if_pc !== 32'h34) begin errors++; $display("FAIL rm_pre got rv=%b if_pc=%h want rv=0 if_pc=34", imem_req_valid, if_pc); end
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL rm_regs got pc=%h if_pc=%h ins=%h want 0 0 0", pc, if_pc, if_instr); end
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || fetch_count !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rm_ctl got v=%b rv=%b cnt=%0d err=%b want all 0", if_valid, imem_req_valid, fetch_count, misalign_err); end
    step();
    rst = 1'b0;
    step();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL rm_first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_out();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
